// File: rtl/fp_sum_squares_pkg.sv
// rtl/fp_sum_squares_pkg.sv - shared types and helpers for the fp_sum_squares slice
package fp_sum_squares_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MUL,
        ST_ACC,
        ST_DONE
    } state_t;

    // Radix-2 shift-add retires one multiplier bit per cycle.
    function automatic int mul_cycles(input int width);
        return width;
    endfunction

    function automatic int cnt_bits(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/fp_sum_squares_if.sv
// rtl/fp_sum_squares_if.sv - element stream in, go/done result out
interface fp_sum_squares_if #(
    parameter int WIDTH = 32
);
    logic             go;
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             done;

    modport master (
        output go, in, in_valid, in_last,
        input  in_ready, out, done
    );

    modport slave (
        input  go, in, in_valid, in_last,
        output in_ready, out, done
    );
endinterface

// File: rtl/seq_mul_unsigned.sv
// rtl/seq_mul_unsigned.sv - WIDTH x WIDTH radix-2 shift-add multiplier, WIDTH-cycle latency
module seq_mul_unsigned
    import fp_sum_squares_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int ITER = mul_cycles(WIDTH);
    localparam int CW   = cnt_bits(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    logic [WIDTH-1:0] mcand_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   partial;

    // Multiplier bits sit in the low half and shift out as the product grows in from the top.
    assign partial = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand_q} : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            product <= '0;
        end else if (start && !busy) begin
            mcand_q <= a;
            product <= {{WIDTH{1'b0}}, b};
            cnt_q   <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            product <= {partial, product[WIDTH-1:1]};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy <= 1'b0;
            end
        end
    end

    // Flags the final iteration; product is complete from the following cycle.
    assign done = busy && (cnt_q == LAST);

endmodule

// File: rtl/fp_sum_squares.sv
// rtl/fp_sum_squares.sv - fixed-point sum of squares; FP_SUM_SQUARES_SAT_EN selects saturating accumulation
module fp_sum_squares
    import fp_sum_squares_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input logic             clk,
    input logic             reset,
    fp_sum_squares_if.slave bus
);
    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_cfg_check
        $error("INT_WIDTH + FRAC_WIDTH must equal WIDTH");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mag;
    logic [WIDTH-1:0]   acc_q, acc_d, out_q;
    logic               last_q, done_q;
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] product, aligned;
    logic [WIDTH:0]     sum;

    // Most-negative input maps onto 2^(WIDTH-1), which still fits unsigned.
    assign mag       = bus.in[WIDTH-1] ? (~bus.in + 1'b1) : bus.in;
    assign mul_start = (state_q == ST_WAIT) && bus.in_valid && !mul_busy;

    seq_mul_unsigned #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (mag),
        .b       (mag),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    assign aligned = product >> FRAC_WIDTH;
    assign sum     = {1'b0, acc_q} + {1'b0, aligned[WIDTH-1:0]};

`ifdef FP_SUM_SQUARES_SAT_EN
    // Once all-ones, any further non-negative add keeps it all-ones.
    assign acc_d = ((|aligned[2*WIDTH-1:WIDTH]) || sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
`else
    logic unused_wrap_bits;
    assign unused_wrap_bits = ^{aligned[2*WIDTH-1:WIDTH], sum[WIDTH]};
    assign acc_d = sum[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.go)       state_d = ST_WAIT;
            ST_WAIT: if (bus.in_valid) state_d = ST_MUL;
            ST_MUL:  if (mul_done)     state_d = ST_ACC;
            ST_ACC:  state_d = last_q ? ST_DONE : ST_WAIT;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            last_q  <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == ST_DONE);
            if (state_q == ST_IDLE && bus.go) begin
                acc_q <= '0;
            end
            if (state_q == ST_WAIT && bus.in_valid) begin
                last_q <= bus.in_last;
            end
            if (state_q == ST_ACC) begin
                acc_q <= acc_d;
                if (last_q) begin
                    out_q <= acc_d;
                end
            end
        end
    end

    assign bus.in_ready = (state_q == ST_WAIT);
    assign bus.out      = out_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_fp_sum_squares.sv
// tb/tb_fp_sum_squares.sv - scoreboard bench for fp_sum_squares (Q16.16 and integer-mode instances)
module tb_fp_sum_squares;
    localparam int WIDTH = 32;
    localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_sum_squares_if #(.WIDTH(WIDTH)) bus ();
    fp_sum_squares_if #(.WIDTH(WIDTH)) bus_i ();

    fp_sum_squares #(.WIDTH(WIDTH), .INT_WIDTH(16), .FRAC_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fp_sum_squares #(.WIDTH(WIDTH), .INT_WIDTH(32), .FRAC_WIDTH(0)) dut_int (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    assign bus_i.go       = bus.go;
    assign bus_i.in       = bus.in;
    assign bus_i.in_valid = bus.in_valid;
    assign bus_i.in_last  = bus.in_last;

    int            n_vec = 0;
    int            n_err = 0;
    logic [31:0]   job[$];
    logic [31:0]   exp_q[$];
    logic [31:0]   exp_i_q[$];
    logic [31:0]   last_out = 32'd0;
    logic          prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Reference: sum of (|x|^2 >> frac) in wide arithmetic, then clamp or wrap to 32 bits.
    function automatic logic [31:0] model(input int frac);
        longint unsigned acc = 0;
        longint unsigned sq;
        logic [31:0] m;
        for (int i = 0; i < job.size(); i++) begin
            m  = job[i][31] ? (32'd0 - job[i]) : job[i];
            sq = ({32'd0, m} * {32'd0, m}) >> frac;
`ifdef FP_SUM_SQUARES_SAT_EN
            if (sq > MAXV || acc + sq > MAXV) acc = MAXV;
            else acc = acc + sq;
`else
            acc = (acc + sq) & MAXV;
`endif
        end
        return acc[31:0];
    endfunction

    function automatic logic [31:0] rand_elem();
        logic [31:0] v;
        if ($urandom_range(0, 3) == 0) v = $urandom;
        else v = $urandom_range(0, 32'h00FF_FFFF);
        if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                check("done_one_cycle", 32'(prev_done), 32'd0);
                check("pending_jobs", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) check("out", bus.out, exp_q.pop_front());
            end
            if (bus_i.done) begin
                check("int_pending_jobs", 32'(exp_i_q.size()), 32'd1);
                if (exp_i_q.size() > 0) check("int_out", bus_i.out, exp_i_q.pop_front());
            end
        end
        prev_done = bus.done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input bit hold, input bit go_mid, input bit go_in_done);
        int cnt;
        check("out_held", bus.out, last_out);
        last_out = model(16);
        exp_q.push_back(last_out);
        exp_i_q.push_back(model(0));
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        for (int i = 0; i < job.size(); i++) begin
            if (!hold) repeat ($urandom_range(0, 2)) step();
            bus.in       = job[i];
            bus.in_last  = (i == job.size() - 1);
            bus.in_valid = 1'b1;
            cnt = 0;
            while (!bus.in_ready && cnt < 100) begin
                step();
                cnt++;
            end
            if (cnt >= 100) begin
                n_vec++;
                n_err++;
                $display("FAIL ready_timeout: waited %0d cycles, required < 100", cnt);
            end
            step();
            if (!hold) bus.in_valid = 1'b0;
            if (go_mid && i == 0) begin
                bus.go = 1'b1;
                step();
                bus.go = 1'b0;
            end
            if (hold && i != job.size() - 1) begin
                cnt = 0;
                while (!bus.in_ready && cnt < 100) begin
                    cnt++;
                    step();
                end
                check("ready_low_cycles", cnt, WIDTH + 1);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        cnt = (go_mid && job.size() == 1) ? 1 : 0;
        while (!bus.done && cnt < 200) begin
            step();
            cnt++;
        end
        check("done_latency", cnt, WIDTH + 1);
        if (go_in_done) bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        check("idle_after_done", 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        bus.go       = 1'b0;
        bus.in       = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (3) step();
        check("reset_out", bus.out, 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        step();

        job = {32'h0001_0000, 32'h0002_0000};
        run_job(1'b0, 1'b0, 1'b0);
        job = {32'hFFFD_0000};
        run_job(1'b0, 1'b0, 1'b1);
        job = {32'h8000_0000};
        run_job(1'b0, 1'b0, 1'b0);
        job = {32'h0100_0000};
        run_job(1'b0, 1'b0, 1'b0);
        job = {32'd3, 32'd4};
        run_job(1'b0, 1'b1, 1'b0);
        job = {32'h0000_8000, 32'hFFFF_0000, 32'h0003_0000};
        run_job(1'b1, 1'b0, 1'b0);

        for (int j = 0; j < 20; j++) begin
            job = {};
            for (int k = 0; k < $urandom_range(1, 4); k++) job.push_back(rand_elem());
            run_job(j % 5 == 0, j % 3 == 1, j % 4 == 2);
        end

        job = {32'h0005_0000};
        run_job(1'b0, 1'b0, 1'b0);
        bus.go = 1'b1;
        step();
        bus.go       = 1'b0;
        bus.in       = 32'h0001_2345;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mul_reset_out", bus.out, 32'd0);
        check("mul_reset_done", 32'(bus.done), 32'd0);
        check("mul_reset_in_ready", 32'(bus.in_ready), 32'd0);
        last_out = 32'd0;
        job = {32'h0003_0000};
        run_job(1'b0, 1'b0, 1'b0);

        repeat (3) step();
        check("jobs_outstanding", 32'(exp_q.size()), 32'd0);
        check("int_jobs_outstanding", 32'(exp_i_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
